// File: rtl/dma_fifo_device.sv
// FIFO-buffered DMA peripheral on the openMSP430 peripheral bus.
// Optional macro DMA_FIFO_IRQ_EN adds the irq port and CONFIG.IRQ_EN bit.
module dma_fifo_device #(
  parameter logic [14:0] BASE_ADDR = 15'h0100,
  parameter int          DEC_WD    = 4,
  parameter int          FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [15:0] dev_in,
  input  logic        dma_ack,
  input  logic        dma_end_flag,
  output logic        dma_rqst,
  output logic        dma_rd_wr,
  output logic [15:0] dma_start_address,
  output logic [15:0] dma_num_words,
  output logic        dev_ack,
  output logic [15:0] dev_out
`ifdef DMA_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [15:0]        r_start_addr;
  logic [15:0]        r_n_words;
  logic [15:0]        r_remain;
  logic               r_rd_wr;
  logic               r_done;
  logic               r_err;
  logic [1:0]         r_state;
  logic [15:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_level;

  logic        w_sel, w_wr, w_rd, w_busy, w_empty, w_full, w_beat;
  logic [7:0]  w_idx;
  logic        w_cfg_wr, w_status_wr, w_start, w_abort, w_flush;
  logic        w_data_wr, w_data_rd;
  logic        w_push_req, w_pop_req, w_push, w_pop, w_err_set;
  logic [15:0] w_push_data, w_head;
  logic        w_irq_en;

  assign w_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign w_idx = 8'(per_addr[DEC_WD-2:0]);
  assign w_wr  = w_sel & (|per_we);
  assign w_rd  = w_sel & ~(|per_we);

  assign w_cfg_wr    = w_wr & (w_idx == 8'd2);
  assign w_status_wr = w_wr & (w_idx == 8'd3);
  assign w_data_wr   = w_wr & (w_idx == 8'd4);
  assign w_data_rd   = w_rd & (w_idx == 8'd4);
  assign w_start     = w_cfg_wr & per_din[0];
  assign w_abort     = w_cfg_wr & per_din[3];
  assign w_flush     = w_cfg_wr & per_din[4];

  // Level never exceeds DEPTH, so its top bit alone marks a full FIFO.
  assign w_empty = (r_level == '0);
  assign w_full  = r_level[FIFO_AW];
  assign w_busy  = (r_state == ST_RUN);
  assign w_head  = r_mem[r_rptr];

  assign dma_rqst          = w_busy;
  assign dma_rd_wr         = r_rd_wr;
  assign dma_start_address = r_start_addr;
  assign dma_num_words     = r_n_words;
  assign dev_ack           = r_rd_wr ? ~w_full : ~w_empty;
  assign dev_out           = w_empty ? 16'h0000 : w_head;
  assign w_beat            = dma_rqst & dma_ack & dev_ack;

  // Read mode: DMA fills, CPU drains. Write mode: CPU fills, DMA drains.
  assign w_push_req  = r_rd_wr ? w_beat : w_data_wr;
  assign w_pop_req   = r_rd_wr ? w_data_rd : w_beat;
  assign w_push_data = r_rd_wr ? dev_in : per_din;
  assign w_pop       = w_pop_req & ~w_empty;
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_err_set   = (w_pop_req & w_empty) | (w_push_req & ~w_push);

`ifdef DMA_FIFO_IRQ_EN
  logic r_irq_en;
  assign w_irq_en = r_irq_en;
  assign irq      = r_done & r_irq_en;

  always_ff @(posedge clk) begin
    if (reset)         r_irq_en <= 1'b0;
    else if (w_cfg_wr) r_irq_en <= per_din[5];
  end
`else
  assign w_irq_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_addr <= '0;
      r_n_words    <= '0;
      r_remain     <= '0;
      r_rd_wr      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_state      <= ST_IDLE;
    end else begin
      if (w_wr && (w_idx == 8'd0) && !w_busy) r_start_addr <= per_din;
      if (w_wr && (w_idx == 8'd1) && !w_busy) r_n_words    <= per_din;
      if (w_cfg_wr && !w_busy) r_rd_wr <= per_din[2];

      if (w_err_set)                      r_err <= 1'b1;
      else if (w_status_wr && per_din[4]) r_err <= 1'b0;

      if (w_status_wr && per_din[1]) r_done <= 1'b0;
      if (w_beat) r_remain <= r_remain - 16'd1;

      // Completion below overrides a same-cycle DONE clear from the CPU.
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_remain <= r_n_words;
            if (r_n_words == 16'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (dma_end_flag || (w_beat && (r_remain == 16'd1))) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (w_rd) begin
      case (w_idx)
        8'd0:    per_dout = r_start_addr;
        8'd1:    per_dout = r_n_words;
        8'd2:    per_dout = {10'b0, w_irq_en, 2'b00, r_rd_wr, 2'b00};
        8'd3:    per_dout = {8'(r_level), 3'b000, r_err, w_full, w_empty, r_done, w_busy};
        8'd4:    per_dout = (r_rd_wr && !w_empty) ? w_head : 16'h0000;
        8'd5:    per_dout = r_remain;
        default: per_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_fifo_device.sv
// Scoreboard bench for dma_fifo_device: queue-based reference model predicts
// bus reads and DMA-side outputs; a monitor compares them against the DUT.
module tb_dma_fifo_device;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic        dma_end_flag;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
`ifdef DMA_FIFO_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  dma_fifo_device dut (
    .clk(clk), .reset(reset),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout),
    .dev_in(dev_in), .dma_ack(dma_ack), .dma_end_flag(dma_end_flag),
    .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
    .dev_ack(dev_ack), .dev_out(dev_out)
`ifdef DMA_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct {
    logic        rqst;
    logic        ack;
    logic [15:0] out;
    logic        irq;
  } ctl_t;

  ctl_t        ctl_q[$];
  logic [15:0] rd_q[$];
  int          total = 0;
  int          bad = 0;

  // Reference model state
  logic [15:0] m_start, m_nw, m_rem;
  bit          m_rdwr, m_irqen, m_busy, m_done, m_err;
  logic [15:0] m_q[$];

  // Stimulus knobs for the emulated DMA controller
  bit          g_ack = 0, g_end = 0, g_rst = 0, g_auto = 0;
  logic [15:0] g_devin = 16'h0000;

  function void check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  function void model_reset();
    m_start = 0; m_nw = 0; m_rem = 0;
    m_rdwr = 0; m_irqen = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_q.delete();
  endfunction

  function automatic logic [15:0] readval(int idx);
    int n = m_q.size();
    case (idx)
      0: return m_start;
      1: return m_nw;
      2: return 16'((m_irqen ? 32 : 0) + (m_rdwr ? 4 : 0));
      3: return 16'(n * 256 + (m_err ? 16 : 0) + (n == DEPTH ? 8 : 0) +
                    (n == 0 ? 4 : 0) + (m_done ? 2 : 0) + (m_busy ? 1 : 0));
      4: return (m_rdwr && n > 0) ? m_q[0] : 16'h0000;
      5: return m_rem;
      default: return 16'h0000;
    endcase
  endfunction

  // One bus cycle: drive inputs, queue expectations, advance the model.
  task automatic step(input bit en, input bit wr, input bit sel, input int idx,
                      input logic [15:0] din, input bit use_c, input logic [15:0] cval);
    ctl_t        c;
    bit          s_wr, s_rd, dack, beat, pop_req, push_req, set_err, old_busy, old_rdwr;
    logic [15:0] pword;
    @(negedge clk);
    reset        = g_rst;
    per_en       = en;
    per_we       = (en && wr) ? 2'($urandom_range(1, 3)) : 2'b00;
    per_addr     = (sel ? 14'h0080 : 14'h00C0) + 14'(idx);
    per_din      = din;
    dma_ack      = g_ack;
    dev_in       = g_devin;
    dma_end_flag = g_end;

    s_wr = en && sel && wr;
    s_rd = en && sel && !wr;
    dack = m_rdwr ? (m_q.size() < DEPTH) : (m_q.size() > 0);
    c.rqst = m_busy;
    c.ack  = dack;
    c.out  = (m_q.size() > 0) ? m_q[0] : 16'h0000;
    c.irq  = m_done && m_irqen;
    ctl_q.push_back(c);
    if (en && !wr) rd_q.push_back(use_c ? cval : (sel ? readval(idx) : 16'h0000));
    if (g_rst) begin
      model_reset();
      return;
    end

    old_busy = m_busy;
    old_rdwr = m_rdwr;
    beat     = m_busy && g_ack && dack;
    pop_req  = m_rdwr ? (s_rd && idx == 4) : beat;
    push_req = m_rdwr ? beat : (s_wr && idx == 4);
    pword    = m_rdwr ? g_devin : din;
    set_err  = 0;
    if (pop_req) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else set_err = 1;
    end
    if (push_req) begin
      if (m_q.size() < DEPTH) m_q.push_back(pword);
      else set_err = 1;
    end
    if (s_wr && idx == 2 && din[4]) m_q.delete();

    if (s_wr && idx == 0 && !old_busy) m_start = din;
    if (s_wr && idx == 1 && !old_busy) m_nw = din;
    if (s_wr && idx == 2) begin
      if (!old_busy) m_rdwr = din[2];
`ifdef DMA_FIFO_IRQ_EN
      m_irqen = din[5];
`endif
    end
    if (s_wr && idx == 3) begin
      if (din[1]) m_done = 0;
      if (din[4]) m_err = 0;
    end
    if (set_err) m_err = 1;

    if (old_busy) begin
      if (beat) m_rem = m_rem - 1;
      if (s_wr && idx == 2 && din[3]) m_busy = 0;
      else if (g_end || (beat && m_rem == 0)) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (s_wr && idx == 2 && din[0]) begin
      m_rem = m_nw;
      if (m_nw == 0) m_done = 1;
      else begin
        m_busy = 1;
        m_done = 0;
      end
    end
    if (beat && old_rdwr && g_auto) g_devin = g_devin + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1, 0, 16'h0, 0, 16'h0);
  endtask
  task automatic wr(input int idx, input logic [15:0] d);
    step(1, 1, 1, idx, d, 0, 16'h0);
  endtask
  task automatic rdc(input int idx, input logic [15:0] v);
    step(1, 0, 1, idx, 16'h0, 1, v);
  endtask

  initial begin
    ctl_t c;
    forever begin
      @(negedge clk);
      #2;
      if (ctl_q.size() > 0) begin
        c = ctl_q.pop_front();
        check("dma_rqst", 16'(dma_rqst), 16'(c.rqst));
        check("dev_ack", 16'(dev_ack), 16'(c.ack));
        check("dev_out", dev_out, c.out);
`ifdef DMA_FIFO_IRQ_EN
        check("irq", 16'(irq), 16'(c.irq));
`endif
      end
      if (per_en === 1'b1 && per_we === 2'b00) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL per_dout: read with no expectation, got %h", per_dout);
        end else begin
          check("per_dout", per_dout, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    int idx, op;
    bit w, s;
    logic [15:0] d;
    logic [15:0] cfg_tab [8];
    cfg_tab = '{16'h0001, 16'h0005, 16'h0004, 16'h0000, 16'h0008, 16'h0010, 16'h0021, 16'h0025};

    reset = 1; per_en = 0; per_we = 0; per_addr = 0; per_din = 0;
    dev_in = 0; dma_ack = 0; dma_end_flag = 0;
    repeat (2) @(negedge clk);
    model_reset();

    // reset state and wrong-mode read
    rdc(3, 16'h0004); rdc(4, 16'h0000); rdc(3, 16'h0004); rdc(2, 16'h0000); rdc(5, 16'h0000);

    // read mode, 4 words
    wr(1, 4); g_ack = 1; g_devin = 16'hA001; g_auto = 1;
    wr(2, 16'h0005); idle(6);
    rdc(3, 16'h0402); rdc(5, 16'h0000);
    rdc(4, 16'hA001); rdc(4, 16'hA002); rdc(4, 16'hA003); rdc(4, 16'hA004);
    rdc(3, 16'h0006);

    // read mode overflow, back-pressure, abort, flush, pop-empty error
    wr(3, 16'h0012); wr(1, 10); g_devin = 16'hB000;
    wr(2, 16'h0005); idle(12);
    rdc(5, 16'h0002); rdc(3, 16'h0809);
    rdc(4, 16'hB000); idle(2); rdc(5, 16'h0001);
    wr(2, 16'h0008); idle(1);
    rdc(3, 16'h0808); rdc(5, 16'h0001); rdc(4, 16'hB001);
    wr(2, 16'h0014); rdc(4, 16'h0000); rdc(3, 16'h0014);

    // write mode, two words
    wr(3, 16'h0012); g_ack = 0; g_auto = 0; wr(2, 16'h0000);
    wr(4, 16'h1111); wr(4, 16'h2222); wr(1, 2); g_ack = 1;
    wr(2, 16'h0001); idle(4);
    rdc(3, 16'h0006); rdc(5, 16'h0000);

    // end flag mid-transfer, irq and DONE clear
    wr(3, 16'h0012); g_ack = 0;
    wr(4, 16'h3333); wr(4, 16'h3334); wr(4, 16'h3335); wr(1, 8);
    wr(2, 16'h0021); g_ack = 1; idle(3); g_ack = 0;
    rdc(5, 16'h0005);
    g_end = 1; idle(1); g_end = 0; idle(1);
    rdc(3, 16'h0006);
    wr(3, 16'h0002); rdc(3, 16'h0004);

    // zero-length start, writes while busy, start in RUN, reset mid-run
    wr(1, 0); wr(2, 16'h0001); rdc(3, 16'h0006); rdc(5, 16'h0000);
    wr(1, 3); wr(2, 16'h0001); rdc(3, 16'h0005);
    wr(1, 7); rdc(1, 16'h0003); wr(0, 16'h1234); rdc(0, 16'h0000);
    wr(2, 16'h0001); rdc(5, 16'h0003);
    g_rst = 1; idle(1); g_rst = 0;
    rdc(3, 16'h0004); rdc(1, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      g_ack   = ($urandom % 4) != 0;
      g_devin = 16'($urandom);
      g_end   = ($urandom % 60) == 0;
      g_rst   = ($urandom % 700) == 0;
      op      = $urandom % 8;
      if (g_rst || op < 3) begin
        idle(1);
      end else begin
        idx = $urandom % 6;
        s   = ($urandom % 16) != 0;
        w   = ($urandom % 2) == 1;
        case (idx)
          1:       d = 16'($urandom_range(0, 12));
          2:       d = cfg_tab[$urandom % 8];
          default: d = 16'($urandom);
        endcase
        step(1, w, s, idx, d, 0, 16'h0);
      end
    end
    g_end = 0; g_rst = 0; g_ack = 0;
    idle(3);
    check("rd_q_drained", 16'(rd_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
